// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared types and constants for the PC sequencer and for
//               anything else that decodes branch condition codes.
// Revision    : 1.0  initial release
// ============================================================================
package pc_pkg;

    typedef enum logic [2:0] {
        NEQ    = 3'b000,
        EQ     = 3'b001,
        GT     = 3'b010,
        LT     = 3'b011,
        GTE    = 3'b100,
        LTE    = 3'b101,
        OVFL   = 3'b110,
        UNCOND = 3'b111
    } ccc_e;

    // Bit positions inside the {Z,V,N} flag vector
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_sequencer_branch_cond.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond
// Description : Combinational decode of the 3-bit condition code against
//               the {Z,V,N} flags.
// Revision    : 1.0  initial release
// ============================================================================
module branch_cond
    import pc_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       cond_true
);

    logic w_z;
    logic w_v;
    logic w_n;

    assign w_z = flags[FLAG_Z];
    assign w_v = flags[FLAG_V];
    assign w_n = flags[FLAG_N];

    always_comb begin
        cond_true = 1'b0;
        case (ccc_e'(ccc))
            NEQ:    cond_true = ~w_z;
            EQ:     cond_true = w_z;
            GT:     cond_true = ~w_z & ~w_n;
            LT:     cond_true = w_n;
            GTE:    cond_true = w_z | (~w_z & ~w_n);
            LTE:    cond_true = w_n | w_z;
            OVFL:   cond_true = w_v;
            UNCOND: cond_true = 1'b1;
        endcase
    end

endmodule : branch_cond
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch-stage PC register, flag register, HLT state machine
//               and next-PC selection for sequential, B and BR flow.
// Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                IMM_W    = 9,
    parameter int                INC      = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_valid,
    input  logic              is_br,
    input  logic [2:0]        ccc,
    input  logic [IMM_W-1:0]  imm,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              halt,
    input  logic [2:0]        flag_we,
    input  logic [2:0]        flags_in,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_inc,
    output logic              taken,
    output logic              flush,
    output logic              halted,
    output logic [2:0]        flags
);

    localparam logic [ADDR_W-1:0] c_inc       = ADDR_W'(INC);
    localparam logic [ADDR_W-1:0] c_even_mask = {{(ADDR_W-1){1'b1}}, 1'b0};

    logic [ADDR_W-1:0] r_pc;
    logic [2:0]        r_flags;
    logic              r_flush;
    state_e            r_state;

    logic              w_cond;
    logic              w_accept;
    logic [ADDR_W-1:0] w_imm_ext;
    logic [ADDR_W-1:0] w_b_target;
    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_pc_next;

    branch_cond u_branch_cond (
        .ccc       (ccc),
        .flags     (r_flags),
        .cond_true (w_cond)
    );

    assign pc     = r_pc;
    assign flags  = r_flags;
    assign flush  = r_flush;
    assign halted = (r_state == HALTED);
    assign pc_inc = r_pc + c_inc;

    // halt outranks a branch presented in the same cycle
    assign w_accept = br_valid & ~stall & ~halt & (r_state == RUN);
    assign taken    = w_accept & w_cond;

    // Immediate counts instruction words; shift converts to bytes
    assign w_imm_ext   = ADDR_W'($signed(imm));
    assign w_b_target  = pc_inc + (w_imm_ext << 1);
    assign w_br_target = br_target & c_even_mask;

    always_comb begin
        w_pc_next = pc_inc;
        if (taken) begin
            w_pc_next = is_br ? w_br_target : w_b_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_flush <= 1'b0;
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (stall) begin
                        r_flush <= 1'b0;
                    end else if (halt) begin
                        r_flush <= 1'b0;
                        r_state <= HALTED;
                    end else begin
                        r_pc    <= w_pc_next;
                        r_flush <= taken;
                    end
                end
                HALTED: begin
                    r_flush <= 1'b0;
                end
                default: begin
                    r_flush <= 1'b0;
                    r_state <= RUN;
                end
            endcase
        end
    end

    // Flag writes ignore stall and halt; no bypass into this cycle's decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (flag_we[i]) begin
                    r_flags[i] <= flags_in[i];
                end
            end
        end
    end

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer: directed scenarios plus
//               randomized traffic against a behavioural reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_valid;
    logic        is_br;
    logic [2:0]  ccc;
    logic [8:0]  imm;
    logic [15:0] br_target;
    logic        halt;
    logic [2:0]  flag_we;
    logic [2:0]  flags_in;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic        taken;
    logic        flush;
    logic        halted;
    logic [2:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_pc;
    logic [2:0]  m_flags;
    bit          m_halted;
    bit          m_flush;

    pc_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_valid  (br_valid),
        .is_br     (is_br),
        .ccc       (ccc),
        .imm       (imm),
        .br_target (br_target),
        .halt      (halt),
        .flag_we   (flag_we),
        .flags_in  (flags_in),
        .pc        (pc),
        .pc_inc    (pc_inc),
        .taken     (taken),
        .flush     (flush),
        .halted    (halted),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Condition table with flags as {Z,V,N}
    function automatic bit cond_ok(input logic [2:0] c, input logic [2:0] f);
        bit z, v, n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || (!z && !n);
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic idle_inputs();
        stall     = 1'b0;
        br_valid  = 1'b0;
        is_br     = 1'b0;
        ccc       = 3'd0;
        imm       = 9'd0;
        br_target = 16'd0;
        halt      = 1'b0;
        flag_we   = 3'd0;
        flags_in  = 3'd0;
    endtask

    task automatic model_reset();
        m_pc     = 16'h0000;
        m_flags  = 3'b000;
        m_halted = 1'b0;
        m_flush  = 1'b0;
    endtask

    // Entered at posedge+1 with inputs applied; returns at next posedge+1
    task automatic cycle();
        bit          tk;
        int          nxt;
        logic [2:0]  nf;
        #3;
        tk = br_valid && !stall && !halt && !m_halted && cond_ok(ccc, m_flags);
        check_eq("pc", pc, m_pc);
        check_eq("pc_inc", pc_inc, (int'(m_pc) + 2) & 32'hFFFF);
        check_eq("flags", flags, m_flags);
        check_eq("flush", flush, m_flush);
        check_eq("halted", halted, m_halted);
        check_eq("taken", taken, tk);
        nxt = int'(m_pc);
        if (!m_halted && !stall && !halt) begin
            if (tk && is_br)
                nxt = int'(br_target) & 32'hFFFE;
            else if (tk)
                nxt = (int'(m_pc) + 2 + 2 * int'($signed(imm))) & 32'hFFFF;
            else
                nxt = (int'(m_pc) + 2) & 32'hFFFF;
        end
        nf = m_flags;
        for (int i = 0; i < 3; i++)
            if (flag_we[i]) nf[i] = flags_in[i];
        @(posedge clk);
        #1;
        if (!m_halted && !stall && halt) m_halted = 1'b1;
        m_pc    = nxt[15:0];
        m_flags = nf;
        m_flush = tk;
    endtask

    // Asynchronous reset mid-cycle; outputs must settle before any edge
    task automatic do_reset();
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("async_rst_pc", pc, 16'h0000);
        check_eq("async_rst_halted", halted, 1'b0);
        check_eq("async_rst_flush", flush, 1'b0);
        check_eq("async_rst_flags", flags, 3'b000);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit exp_t;
        logic [15:0] exp_pc;
        rst = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Sequential run from reset
        for (int k = 0; k < 4; k++) begin
            #3;
            check_eq("seq_pc", pc, 16'(2 * k));
            #1;
            cycle();
        end
        check_eq("seq_pc_end", pc, 16'h0008);

        // Taken B, redirect and single-cycle flush
        do_reset();
        br_valid = 1'b1; ccc = 3'd0; imm = 9'h004;
        cycle();
        idle_inputs();
        check_eq("b_pc", pc, 16'h000A);
        check_eq("b_flush_hi", flush, 1'b1);
        cycle();
        check_eq("b_flush_lo", flush, 1'b0);

        // Condition sweep, flags loaded under stall so pc stays at 0
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                for (int b = 0; b < 2; b++) begin
                    do_reset();
                    stall = 1'b1; flag_we = 3'b111; flags_in = 3'(f);
                    cycle();
                    idle_inputs();
                    br_valid = 1'b1; is_br = b[0]; ccc = 3'(c);
                    imm = 9'h004; br_target = 16'hFF00;
                    exp_t = cond_ok(3'(c), 3'(f));
                    cycle();
                    idle_inputs();
                    exp_pc = !exp_t ? 16'h0002 : (b[0] ? 16'hFF00 : 16'h000A);
                    check_eq("sweep_pc", pc, exp_pc);
                end
            end
        end

        // BR target low bit ignored
        do_reset();
        br_valid = 1'b1; is_br = 1'b1; ccc = 3'd7; br_target = 16'hFF01;
        cycle();
        idle_inputs();
        check_eq("br_odd_pc", pc, 16'hFF00);

        // Flag write not visible to same-cycle branch
        do_reset();
        flag_we = 3'b100; flags_in = 3'b100;
        br_valid = 1'b1; ccc = 3'd1; imm = 9'h004;
        cycle();
        check_eq("nobypass_pc", pc, 16'h0002);
        flag_we = 3'b000;
        cycle();
        idle_inputs();
        check_eq("bypass_next_pc", pc, 16'h000C);

        // Stall held with a taken branch present
        do_reset();
        br_valid = 1'b1; ccc = 3'd7; imm = 9'h010; stall = 1'b1;
        repeat (3) cycle();
        check_eq("stall_pc", pc, 16'h0000);
        stall = 1'b0;
        cycle();
        idle_inputs();
        check_eq("stall_release_pc", pc, 16'h0022);

        // Halt beats branch, persists, async reset leaves HALTED
        do_reset();
        halt = 1'b1; br_valid = 1'b1; ccc = 3'd7; imm = 9'h004;
        cycle();
        idle_inputs();
        br_valid = 1'b1; ccc = 3'd7; imm = 9'h004;
        repeat (10) cycle();
        check_eq("halt_pc", pc, 16'h0000);
        check_eq("halt_persist", halted, 1'b1);
        do_reset();
        br_valid = 1'b1; is_br = 1'b1; ccc = 3'd7; br_target = 16'hFFFE;
        cycle();
        idle_inputs();
        check_eq("wrap_pre", pc, 16'hFFFE);
        cycle();
        check_eq("wrap_pc", pc, 16'h0000);

        // Randomized traffic
        for (int r = 0; r < 1500; r++) begin
            if (m_halted && ($urandom_range(0, 7) == 0)) begin
                do_reset();
            end else begin
                stall     = ($urandom_range(0, 3) == 0);
                halt      = ($urandom_range(0, 59) == 0);
                br_valid  = $urandom_range(0, 1);
                is_br     = $urandom_range(0, 1);
                ccc       = 3'($urandom);
                imm       = 9'($urandom);
                br_target = 16'($urandom);
                flag_we   = 3'($urandom);
                flags_in  = 3'($urandom);
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire
